wb_ram_slave: RTL
=================

// Module: wb_ram_slave
// PURPOSE
//  Wishbone classic (non-pipelined) slave: the responder end of the wb interface's slave modport.
//  Fronts an internal word-addressed RAM with byte-lane writes and a fixed, programmable wait-state count.
//  Sits on the system bus behind the interconnect. Serves as on-chip scratch RAM and as the reference bus target for master verification.
// PARAMETERS
//  ADDR_WIDTH   32  byte-address width of adr_i
//  DATA_WIDTH   32  data bus width; multiple of 8
//  DEPTH        256 RAM words; power of two, >=2
//  WAIT_STATES  1   extra cycles before ack; 0..15
// PORTS
//  clk_i    in   1              single clock; all logic on rising edge
//  rst_i    in   1              asynchronous reset, active-low
//  cyc_i    in   1              bus cycle active
//  stb_i    in   1              strobe; request valid when cyc_i&stb_i
//  we_i     in   1              1=write, 0=read
//  adr_i    in   ADDR_WIDTH     byte address
//  sel_i    in   DATA_WIDTH/8   byte-lane select
//  dat_i    in   DATA_WIDTH     write data (master->slave)
//  dat_o    out  DATA_WIDTH     read data (slave->master)
//  ack_o    out  1              transfer acknowledge, one-cycle pulse
//  err_o    out  1              error terminate (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, ack_o=0, err_o=0, dat_o=0, wait counter=0. RAM contents are not reset.
//  Word index = adr_i[LSB +: log2(DEPTH)], where LSB=log2(DATA_WIDTH/8). Low LSB bits are ignored.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: on a clock edge with cyc_i&stb_i, latch adr/we/sel/dat and the decode result.
//         Next state is RESP if WAIT_STATES==0; otherwise WAIT with cnt=WAIT_STATES-1.
//   WAIT: decrement cnt each cycle. Go to RESP after the cycle in which cnt==0.
//         If cyc_i==0 on any WAIT edge: abort to IDLE. No write, no ack, no err.
//   RESP: ack_o=1 (or err_o=1) for exactly this one cycle. Then go to IDLE unconditionally.
//  Latency: request sampled at edge N -> ack_o high in the cycle after edge N+WAIT_STATES.
//   Minimum latency is 1 cycle; ack_o is registered, never combinational from stb_i.
//  Back-to-back: IDLE must see a fresh cyc_i&stb_i after RESP. Max throughput is 1 transfer per WAIT_STATES+2 cycles.
//  Write: RAM lanes with sel_i[b]=1 are updated from latched dat at the RESP edge. sel=0 writes nothing but still acks.
//  Read: dat_o is loaded from RAM[latched index] on entry to RESP and is valid while ack_o=1.
//   dat_o holds that value until the next read completes. Writes never change dat_o.
//  Read-after-write to the same word in consecutive transfers returns the new data.
//  Latched request fields are used throughout; adr_i/dat_i changes after sampling are ignored.
//  ack_o and err_o are never both 1. Async reset mid-transfer drops to IDLE immediately and suppresses any pending write.
// CONFIGURATION
//  WB_RAM_SLAVE_ERR_EN defined:
//   Any nonzero adr_i bit above the index field marks the request out-of-range.
//   Out-of-range requests pass through WAIT identically, but RESP asserts err_o instead of ack_o.
//   No RAM write occurs, and dat_o is unchanged.
//  Macro undefined:
//   Upper address bits are ignored; the address aliases onto RAM.
//   err_o is tied to 0 and decode logic is not generated.
// TESTING
//  1. Reset: hold rst_i=0 with clk running -> ack_o=0, err_o=0, dat_o=0. Release -> outputs stay 0 while cyc_i=0.
//  2. Write/read, WAIT_STATES=1: write 0xDEADBEEF to adr 0x10, sel=4'hF -> ack_o high for 1 cycle, 2 cycles after the request edge.
//     Then read 0x10 -> dat_o=0xDEADBEEF with ack_o.
//  3. Byte lanes: word holds 0xDEADBEEF; write 0x11223344 to the same word with sel=4'b0101 -> read returns 0xDE22BE44.
//  4. Abort: WAIT_STATES=3; start a write of 0xCAFEF00D to 0x20, then drop cyc_i after 1 cycle.
//     -> no ack_o/err_o; a read of 0x20 returns the previous contents.
//  5. Wrap/error, DEPTH=256: write 0xA5A5A5A5 to adr 0x400.
//     Without macro: ack_o, and a read of 0x000 returns 0xA5A5A5A5.
//     With WB_RAM_SLAVE_ERR_EN: err_o=1 for 1 cycle, ack_o=0, and word 0 is unchanged.
//  6. Zero wait, WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 -> each ack arrives 1 cycle after its request edge.
//     ack_o is never high on 2 consecutive cycles; data matches.

Source files
------------

// File: rtl/wb_ram_slave_if.sv
// wb_ram_slave_if: Wishbone classic bus bundle.
// Signal names are taken from the slave's point of view.
//   cyc_i, stb_i, we_i     cycle, strobe, write enable  (master -> slave)
//   adr_i, sel_i, dat_i    byte address, lane select, write data  (master -> slave)
//   dat_o, ack_o, err_o    read data, acknowledge, error  (slave -> master)
// Modports: slave (responder), master (initiator).
interface wb_ram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone classic slave fronting a word-addressed RAM with
// byte-lane writes and a fixed number of wait states before the response.
// Ports:
//   clk_i  single clock, rising edge
//   rst_i  asynchronous reset, active low (RAM contents are not reset)
//   bus    wb_ram_slave_if.slave (cyc/stb/we/adr/sel/dat_i in; dat_o/ack_o/err_o out)
// Optional feature: define WB_RAM_SLAVE_ERR_EN to flag requests with any
// nonzero address bit above the word index; those get err_o instead of ack_o
// and neither write the RAM nor change dat_o. Without it, upper address bits
// alias onto the RAM and err_o is tied low.
//
// state  | meaning
// S_IDLE | waiting for cyc_i & stb_i; latches the request
// S_WAIT | counting wait states; cyc_i low aborts the transfer
// S_RESP | ack_o (or err_o) high for this one cycle; RAM write at its end
module wb_ram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_ram_slave_if.slave       bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic                  we_q;
  logic [NB-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] rdat_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req;
  logic [IW-1:0]         idx_in;
  logic                  oor_in;
  logic                  unused_adr;

  assign req        = bus.cyc_i & bus.stb_i;
  assign idx_in     = bus.adr_i[LSB +: IW];
  assign unused_adr = ^bus.adr_i;

`ifdef WB_RAM_SLAVE_ERR_EN
  if (ADDR_WIDTH > LSB + IW) begin : g_decode
    assign oor_in = |bus.adr_i[ADDR_WIDTH-1:LSB+IW];
  end else begin : g_no_decode
    assign oor_in = 1'b0;
  end
  assign bus.err_o = err_q;
`else
  assign oor_in    = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  assign bus.ack_o = ack_q;
  assign bus.dat_o = rdat_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      oor_q  <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_q <= idx_in;
            we_q  <= bus.we_i;
            sel_q <= bus.sel_i;
            dat_q <= bus.dat_i;
            oor_q <= oor_in;
            if (WAIT_STATES == 0) begin
              // Zero wait: latched fields are not yet visible, use live ones.
              state <= S_RESP;
              ack_q <= ~oor_in;
              err_q <= oor_in;
              if (!bus.we_i && !oor_in) rdat_q <= mem[idx_in];
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!bus.cyc_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= S_RESP;
            ack_q <= ~oor_q;
            err_q <= oor_q;
            if (!we_q && !oor_q) rdat_q <= mem[idx_q];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write commits on the edge leaving S_RESP; reset forces S_IDLE
  // asynchronously, so an interrupted write never lands.
  always_ff @(posedge clk_i) begin
    if (state == S_RESP && we_q && !oor_q) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_q[b]) mem[idx_q][b*8 +: 8] <= dat_q[b*8 +: 8];
      end
    end
  end
endmodule
